// File: rtl/ls_queue_param_pkg.sv
// Shared definitions for the load/store queue.
// - Opcode encodings for the memory ops (LB/LH/LW/LBU/LHU/SB/SH/SW).
// - Default width constants.
// - mem_wid byte codes.
// - FSM state type.
// - Small decode and saturating-add helpers.
// Optional build macro used by the queue: LSQ_PERF_CNT_EN.
package ls_queue_param_pkg;

    localparam int LSQ_OP_W  = 6;
    localparam int LSQ_ROB_W = 4;
    localparam int LSQ_XLEN  = 32;

    localparam logic [LSQ_OP_W-1:0] OP_LB  = 6'h01;
    localparam logic [LSQ_OP_W-1:0] OP_LH  = 6'h02;
    localparam logic [LSQ_OP_W-1:0] OP_LW  = 6'h03;
    localparam logic [LSQ_OP_W-1:0] OP_LBU = 6'h04;
    localparam logic [LSQ_OP_W-1:0] OP_LHU = 6'h05;
    localparam logic [LSQ_OP_W-1:0] OP_SB  = 6'h06;
    localparam logic [LSQ_OP_W-1:0] OP_SH  = 6'h07;
    localparam logic [LSQ_OP_W-1:0] OP_SW  = 6'h08;

    localparam logic [2:0] WID_B = 3'd1;
    localparam logic [2:0] WID_H = 3'd2;
    localparam logic [2:0] WID_W = 3'd4;

    typedef enum logic {
        LSQ_IDLE = 1'b0,
        LSQ_BUSY = 1'b1
    } lsq_state_e;

    function automatic logic op_is_store(input logic [LSQ_OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_load(input logic [LSQ_OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic [2:0] op_wid(input logic [LSQ_OP_W-1:0] op);
        logic [2:0] w;
        case (op)
            OP_LB, OP_LBU, OP_SB: w = WID_B;
            OP_LH, OP_LHU, OP_SH: w = WID_H;
            default:              w = WID_W;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/ls_queue_param_load_ext.sv
// lsq_load_ext: combinational load-data extension.
// Ports:
//   op_i   - load opcode.
//   data_i - raw 32-bit memory word.
//   ext_o  - sign- or zero-extended result.
// LW and any non-load opcode pass the data through unchanged.
module lsq_load_ext
    import ls_queue_param_pkg::*;
(
    input  logic [LSQ_OP_W-1:0] op_i,
    input  logic [LSQ_XLEN-1:0] data_i,
    output logic [LSQ_XLEN-1:0] ext_o
);

    always_comb begin
        ext_o = data_i;
        case (op_i)
            OP_LB:   ext_o = {{24{data_i[7]}},  data_i[7:0]};
            OP_LH:   ext_o = {{16{data_i[15]}}, data_i[15:0]};
            OP_LBU:  ext_o = {24'd0, data_i[7:0]};
            OP_LHU:  ext_o = {16'd0, data_i[15:0]};
            default: ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/ls_queue_param.sv
// ls_queue_param: in-order load/store queue between the LS reservation
// station, the ROB and the memory controller.
//
// Ports:
//   clk, rst (sync, active high), rdy (global enable; low freezes everything)
//   Enqueue side: en_i, op_i, addr_i, data_i, id_i
//   ROB side:     commit_i, clr_i
//   Flags:        full_o, empty_o
//   Memory side:  mem_en_o, mem_rw_o, mem_wid_o, mem_addr_o, mem_data_o,
//                 mem_rdy_i, mem_data_i
//   CDB side:     cdb_en_o, cdb_id_o, cdb_data_o
//
// Build option:
//   `define LSQ_PERF_CNT_EN adds saturating counters perf_full_o,
//   perf_busy_o and perf_flush_o.
//
// Pointer layout:
// - head: oldest entry, not yet completed.
// - cmt:  first uncommitted entry.
// - tail: next free slot.
// The extra MSB on each pointer separates full from empty.
module ls_queue_param
    import ls_queue_param_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int IDX_W       = 5,
    parameter int ROB_W       = LSQ_ROB_W,
    parameter int OP_W        = LSQ_OP_W,
    parameter int FULL_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clr_i,
    input  logic             commit_i,
    input  logic             en_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      data_i,
    input  logic [ROB_W-1:0] id_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             mem_en_o,
    output logic             mem_rw_o,
    output logic [2:0]       mem_wid_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    input  logic             mem_rdy_i,
    input  logic [31:0]      mem_data_i,
    output logic             cdb_en_o,
    output logic [ROB_W-1:0] cdb_id_o,
    output logic [31:0]      cdb_data_o
`ifdef LSQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_full_o,
    output logic [31:0]      perf_busy_o,
    output logic [31:0]      perf_flush_o
`endif
);

    localparam logic [IDX_W:0] PTR_DEPTH = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE   = (IDX_W+1)'(1);

    // Entry storage: written at tail; read at head when issuing.
    logic [OP_W-1:0]  op_mem   [DEPTH];
    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [ROB_W-1:0] id_mem   [DEPTH];

    logic [IDX_W:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [IDX_W:0] count_q, count_d;
    logic           full_q, empty_q, full_d, empty_d;
    logic           enq_ok, done;

    lsq_state_e       state_q;
    logic             mem_en_q, mem_rw_q;
    logic [2:0]       mem_wid_q;
    logic [31:0]      mem_addr_q, mem_data_q;
    logic [OP_W-1:0]  busy_op_q;
    logic [ROB_W-1:0] busy_id_q;
    logic             cdb_en_q;
    logic [ROB_W-1:0] cdb_id_q;
    logic [31:0]      cdb_data_q;
    logic [31:0]      ext_data;

    logic [IDX_W-1:0] head_slot, tail_slot;
    logic [OP_W-1:0]  head_op;

    assign head_slot = head_q[IDX_W-1:0];
    assign tail_slot = tail_q[IDX_W-1:0];
    assign head_op   = op_mem[head_slot];
    assign count_q   = tail_q - head_q;

    // A flush in the same cycle wins over enqueue.
    assign enq_ok = en_i && !clr_i && (count_q != PTR_DEPTH);
    assign done   = (state_q == LSQ_BUSY) && mem_rdy_i;

    always_comb begin
        head_d = head_q;
        if (done) head_d = head_q + PTR_ONE;

        cmt_d = cmt_q;
        if (commit_i && (cmt_q != tail_q)) cmt_d = cmt_q + PTR_ONE;

        // Flush drops everything past this cycle's commit point.
        tail_d = tail_q;
        if (clr_i)       tail_d = cmt_d;
        else if (enq_ok) tail_d = tail_q + PTR_ONE;

        count_d = tail_d - head_d;
        full_d  = (DEPTH - int'(count_d)) <= FULL_MARGIN;
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (rdy) begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !rst && enq_ok) begin
            op_mem[tail_slot]   <= op_i;
            addr_mem[tail_slot] <= addr_i;
            data_mem[tail_slot] <= data_i;
            id_mem[tail_slot]   <= id_i;
        end
    end

    // Overflow indicates an upstream bug: the source ignored full_o.
    always_ff @(posedge clk) begin
        if (!rst && rdy && en_i && !clr_i) begin
            assert (count_q != PTR_DEPTH);
        end
    end

    lsq_load_ext u_ext (
        .op_i   (busy_op_q),
        .data_i (mem_data_i),
        .ext_o  (ext_data)
    );

    // Issue FSM.
    // - The op and id are latched at issue, so completion doesn't depend
    //   on the storage read.
    // - The request is held in the registered mem_* outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSQ_IDLE;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_wid_q  <= 3'd0;
            mem_addr_q <= 32'd0;
            mem_data_q <= 32'd0;
            busy_op_q  <= '0;
            busy_id_q  <= '0;
            cdb_en_q   <= 1'b0;
            cdb_id_q   <= '0;
            cdb_data_q <= 32'd0;
        end else if (rdy) begin
            cdb_en_q <= 1'b0;
            case (state_q)
                LSQ_IDLE: begin
                    if (head_q != cmt_q) begin
                        state_q    <= LSQ_BUSY;
                        mem_en_q   <= 1'b1;
                        mem_rw_q   <= op_is_store(head_op);
                        mem_wid_q  <= op_wid(head_op);
                        mem_addr_q <= addr_mem[head_slot];
                        mem_data_q <= data_mem[head_slot];
                        busy_op_q  <= head_op;
                        busy_id_q  <= id_mem[head_slot];
                    end
                end
                LSQ_BUSY: begin
                    if (mem_rdy_i) begin
                        state_q  <= LSQ_IDLE;
                        mem_en_q <= 1'b0;
                        if (op_is_load(busy_op_q)) begin
                            cdb_en_q   <= 1'b1;
                            cdb_id_q   <= busy_id_q;
                            cdb_data_q <= ext_data;
                        end
                    end
                end
                default: state_q <= LSQ_IDLE;
            endcase
        end
    end

`ifdef LSQ_PERF_CNT_EN
    logic [31:0]    perf_full_q, perf_busy_q, perf_flush_q;
    logic [IDX_W:0] flushed;

    assign flushed = tail_q - cmt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_q  <= 32'd0;
            perf_busy_q  <= 32'd0;
            perf_flush_q <= 32'd0;
        end else if (rdy) begin
            if (full_q)               perf_full_q  <= sat_add32(perf_full_q, 32'd1);
            if (state_q == LSQ_BUSY)  perf_busy_q  <= sat_add32(perf_busy_q, 32'd1);
            if (clr_i)                perf_flush_q <= sat_add32(perf_flush_q, 32'(flushed));
        end
    end

    assign perf_full_o  = perf_full_q;
    assign perf_busy_o  = perf_busy_q;
    assign perf_flush_o = perf_flush_q;
`endif

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign mem_en_o   = mem_en_q;
    assign mem_rw_o   = mem_rw_q;
    assign mem_wid_o  = mem_wid_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign cdb_en_o   = cdb_en_q;
    assign cdb_id_o   = cdb_id_q;
    assign cdb_data_o = cdb_data_q;

endmodule
